bcd_count2_scan: RTL and testbench

Two-digit BCD up/down counter with an integrated multiplexed seven-segment driver, sitting directly downstream of `freq_divider` in the two-digit-counter design. It consumes the divider's slow `clkout` as a level input sampled in the system clock domain, counts one step per rising edge of that signal, and drives a two-digit common-anode display. The terminal-count pulse is provided for cascading or for LED indication.

---
 rtl/bcd_count2_scan.sv | 185 ++++++++++++++++++
 tb/tb_bcd_count2_scan.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_count2_scan.sv
// -----------------------------------------------------------------------------
// bcd_count2_scan
//
// Two-digit BCD up/down counter with a multiplexed, common-anode
// seven-segment driver. The slow enable pulse train from the upstream
// divider arrives on tick_in as a level in the clk domain. Each rising
// edge of tick_in is one count step. The count wraps 99 -> 00 going up
// and 00 -> 99 going down. A wrapping step raises tc for exactly one cycle.
//
// Parameters
//   SCAN_DIV   clk cycles each digit is driven before the scan moves on
//              (legal range 2 .. 2**20)
//
// Ports
//   clk        system clock
//   clr        asynchronous active-high reset, clears every register
//   tick_in    divider output, sampled as a level and edge-detected here
//   en         count enable; tick edges are ignored while low
//   up_dn      direction: 1 = count up, 0 = count down
//   load       synchronous load strobe, has priority over counting
//   load_val   BCD load value, [7:4] tens and [3:0] ones; each nibble above 9
//              is clamped to 9
//   ones       registered BCD ones digit
//   tens       registered BCD tens digit
//   tc         registered one-cycle terminal-count pulse
//   an         active-low digit anodes: an[0] drives ones, an[1] drives tens
//   seg        active-low segments, seg[0] = a ... seg[6] = g
// -----------------------------------------------------------------------------
module bcd_count2_scan #(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       tick_in,
  input  logic       en,
  input  logic       up_dn,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic       tc,
  output logic [1:0] an,
  output logic [6:0] seg
);

  // Last value of the scan counter before it wraps and the digit slot
  // changes.
  localparam logic [19:0] SCAN_LAST = 20'(SCAN_DIV - 1);

  // ---------------------------------------------------------------------------
  // Tick edge detection
  // ---------------------------------------------------------------------------
  logic tick_d;
  logic evt;

  // tick_d resets low. If tick_in is already high when clr falls, the first
  // edge after reset therefore counts as an event.
  assign evt = tick_in & ~tick_d;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      tick_d <= 1'b0;
    end else begin
      tick_d <= tick_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Counter next-state logic
  // ---------------------------------------------------------------------------
  logic [3:0] ones_next;
  logic [3:0] tens_next;
  logic       tc_next;

  // Keep a loaded digit inside 0..9 so that the count logic never sees a
  // non-BCD code.
  function automatic logic [3:0] clamp9(input logic [3:0] v);
    return (v > 4'd9) ? 4'd9 : v;
  endfunction

  always_comb begin
    ones_next = ones;
    tens_next = tens;
    tc_next   = 1'b0;

    if (load) begin
      // A load in the same cycle as a tick edge wins, and that edge is lost.
      ones_next = clamp9(load_val[3:0]);
      tens_next = clamp9(load_val[7:4]);
    end else if (en && evt) begin
      if (up_dn) begin
        if (ones < 4'd9) begin
          ones_next = ones + 4'd1;
        end else begin
          ones_next = 4'd0;
          if (tens < 4'd9) begin
            tens_next = tens + 4'd1;
          end else begin
            tens_next = 4'd0;
            tc_next   = 1'b1;
          end
        end
      end else begin
        if (ones > 4'd0) begin
          ones_next = ones - 4'd1;
        end else begin
          ones_next = 4'd9;
          if (tens > 4'd0) begin
            tens_next = tens - 4'd1;
          end else begin
            tens_next = 4'd9;
            tc_next   = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      ones <= 4'd0;
      tens <= 4'd0;
      tc   <= 1'b0;
    end else begin
      ones <= ones_next;
      tens <= tens_next;
      tc   <= tc_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Display scan: each digit slot lasts SCAN_DIV cycles. The scan runs
  // independently of the enable and load inputs.
  // ---------------------------------------------------------------------------
  logic [19:0] scan_cnt;
  logic        sel;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      scan_cnt <= 20'd0;
      sel      <= 1'b0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= 20'd0;
      sel      <= ~sel;
    end else begin
      scan_cnt <= scan_cnt + 20'd1;
    end
  end

  assign an = sel ? 2'b01 : 2'b10;

  // ---------------------------------------------------------------------------
  // Segment decode: both digits are decoded all the time, and sel chooses
  // between them. A digit change therefore shows on seg in the same cycle
  // as the register update.
  // ---------------------------------------------------------------------------
  logic [3:0] digit   [2];
  logic [6:0] seg_dig [2];

  assign digit[0] = ones;
  assign digit[1] = tens;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dec
      always_comb begin
        case (digit[gi])
          4'd0:    seg_dig[gi] = 7'b1000000;
          4'd1:    seg_dig[gi] = 7'b1111001;
          4'd2:    seg_dig[gi] = 7'b0100100;
          4'd3:    seg_dig[gi] = 7'b0110000;
          4'd4:    seg_dig[gi] = 7'b0011001;
          4'd5:    seg_dig[gi] = 7'b0010010;
          4'd6:    seg_dig[gi] = 7'b0000010;
          4'd7:    seg_dig[gi] = 7'b1111000;
          4'd8:    seg_dig[gi] = 7'b0000000;
          4'd9:    seg_dig[gi] = 7'b0010000;
          default: seg_dig[gi] = 7'b1111111;  // blank; unreachable
        endcase
      end
    end
  endgenerate

  assign seg = seg_dig[sel];

endmodule

// File: tb/tb_bcd_count2_scan.sv
// -----------------------------------------------------------------------------
// tb_bcd_count2_scan
//
// Directed bench for bcd_count2_scan with SCAN_DIV = 4. The table of
// per-cycle vectors covers load, clamp, down counting and enable. Separate
// hand-written sequences cover the reset scan pattern, a full up-count wrap,
// the held-high tick level and an asynchronous reset in mid-scan.
// -----------------------------------------------------------------------------
module tb_bcd_count2_scan;

  logic       clk;
  logic       clr;
  logic       tick_in;
  logic       en;
  logic       up_dn;
  logic       load;
  logic [7:0] load_val;
  logic [3:0] ones;
  logic [3:0] tens;
  logic       tc;
  logic [1:0] an;
  logic [6:0] seg;

  int vec_cnt = 0;
  int err_cnt = 0;

  bcd_count2_scan #(.SCAN_DIV(4)) dut (
    .clk      (clk),
    .clr      (clr),
    .tick_in  (tick_in),
    .en       (en),
    .up_dn    (up_dn),
    .load     (load),
    .load_val (load_val),
    .ones     (ones),
    .tens     (tens),
    .tc       (tc),
    .an       (an),
    .seg      (seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       tick;
    logic       en;
    logic       up;
    logic       ld;
    logic [7:0] val;
    int         e_ones;
    int         e_tens;
    int         e_tc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic tk, logic e, logic u, logic l, logic [7:0] v,
                              int eo, int et, int etc);
    vec_t r;
    r.tick = tk; r.en = e; r.up = u; r.ld = l; r.val = v;
    r.e_ones = eo; r.e_tens = et; r.e_tc = etc;
    return r;
  endfunction

  function automatic logic [6:0] seg_of(int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic chk(string name, int act, int exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int exp_v;
  int sel_exp;
  bit found;

  initial begin
    clr = 1'b1; tick_in = 1'b0; en = 1'b0; up_dn = 1'b1;
    load = 1'b0; load_val = 8'h00;

    // ---------------- reset and scan pattern ----------------
    #100;
    clr = 1'b0;
    chk("rst_ones", int'(ones), 0);
    chk("rst_tens", int'(tens), 0);
    chk("rst_tc", int'(tc), 0);
    chk("rst_an", int'(an), 2);
    chk("rst_seg", int'(seg), int'(seg_of(0)));
    for (int k = 1; k <= 16; k++) begin
      step();
      sel_exp = (k / 4) % 2;
      chk($sformatf("scan_an_%0d", k), int'(an), sel_exp ? 1 : 2);
      chk($sformatf("scan_seg_%0d", k), int'(seg), int'(seg_of(0)));
    end

    // ---------------- up count through 99 -> 00 ----------------
    en = 1'b1; up_dn = 1'b1;
    exp_v = 0;
    for (int s = 1; s <= 100; s++) begin
      tick_in = 1'b1;
      step();
      exp_v = (exp_v + 1) % 100;
      chk($sformatf("up_ones_%0d", s), int'(ones), exp_v % 10);
      chk($sformatf("up_tens_%0d", s), int'(tens), exp_v / 10);
      chk($sformatf("up_tc_%0d", s), int'(tc), (exp_v == 0) ? 1 : 0);
      chk($sformatf("up_seg_%0d", s), int'(seg),
          int'(seg_of((an == 2'b01) ? exp_v / 10 : exp_v % 10)));
      tick_in = 1'b0;
      step();
      chk($sformatf("up_tc_low_%0d", s), int'(tc), 0);
      chk($sformatf("up_hold_%0d", s), int'(ones), exp_v % 10);
    end

    // ---------------- table-driven vectors ----------------
    // down from 01: 00, 99 with tc, 98
    tbl.push_back(mk(0, 1, 0, 1, 8'h01, 1, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 8'h00, 9, 9, 1));
    tbl.push_back(mk(0, 1, 0, 0, 8'h00, 9, 9, 0));
    tbl.push_back(mk(1, 1, 0, 0, 8'h00, 8, 9, 0));
    tbl.push_back(mk(0, 1, 0, 0, 8'h00, 8, 9, 0));
    // tens borrow 90 -> 89
    tbl.push_back(mk(0, 1, 0, 1, 8'h90, 0, 9, 0));
    tbl.push_back(mk(1, 1, 0, 0, 8'h00, 9, 8, 0));
    tbl.push_back(mk(0, 1, 0, 0, 8'h00, 9, 8, 0));
    // load wins over a coincident tick edge, with 0xC clamped to 9
    tbl.push_back(mk(1, 1, 1, 1, 8'h3C, 9, 3, 0));
    tbl.push_back(mk(1, 1, 1, 0, 8'h00, 9, 3, 0));
    tbl.push_back(mk(0, 1, 1, 0, 8'h00, 9, 3, 0));
    // clamp on both nibbles, then a plain load
    tbl.push_back(mk(0, 1, 1, 1, 8'hFA, 9, 9, 0));
    tbl.push_back(mk(0, 1, 1, 1, 8'h42, 2, 4, 0));
    // enable low across five tick edges
    for (int i = 0; i < 5; i++) begin
      tbl.push_back(mk(1, 0, 1, 0, 8'h00, 2, 4, 0));
      tbl.push_back(mk(0, 0, 1, 0, 8'h00, 2, 4, 0));
    end

    foreach (tbl[i]) begin
      tick_in = tbl[i].tick; en = tbl[i].en; up_dn = tbl[i].up;
      load = tbl[i].ld; load_val = tbl[i].val;
      step();
      chk($sformatf("tbl%0d_ones", i), int'(ones), tbl[i].e_ones);
      chk($sformatf("tbl%0d_tens", i), int'(tens), tbl[i].e_tens);
      chk($sformatf("tbl%0d_tc", i), int'(tc), tbl[i].e_tc);
    end
    load = 1'b0;

    // ---------------- tick held high for 20 cycles: a single step ----------------
    en = 1'b1; up_dn = 1'b1; tick_in = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      chk($sformatf("level_ones_%0d", c), int'(ones), 3);
      chk($sformatf("level_tens_%0d", c), int'(tens), 4);
    end
    tick_in = 1'b0;
    step();

    // ---------------- async reset with 57 shown on the tens slot ----------------
    load = 1'b1; load_val = 8'h57;
    step();
    load = 1'b0;
    chk("pre_rst_ones", int'(ones), 7);
    chk("pre_rst_tens", int'(tens), 5);
    found = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (an == 2'b01) begin
        found = 1'b1;
        break;
      end
      step();
    end
    chk("wait_sel1", int'(found), 1);
    tick_in = 1'b1;  // high across reset release, so the first edge counts
    #2;
    clr = 1'b1;
    #1;
    chk("async_ones", int'(ones), 0);
    chk("async_tens", int'(tens), 0);
    chk("async_tc", int'(tc), 0);
    chk("async_an", int'(an), 2);
    chk("async_seg", int'(seg), int'(seg_of(0)));
    #2;
    clr = 1'b0;
    step();
    chk("first_edge_ones", int'(ones), 1);
    chk("first_edge_tens", int'(tens), 0);
    chk("first_edge_an", int'(an), 2);
    tick_in = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
